// File: rtl/trdb_pkg.sv
// Shared encodings for the trace controller: FSM states and stop causes.
// Consumed by trdb_trace_ctrl and trdb_drain_timer.
package trdb_pkg;

    localparam logic [1:0] TRDB_ST_IDLE   = 2'd0;
    localparam logic [1:0] TRDB_ST_ACTIVE = 2'd1;
    localparam logic [1:0] TRDB_ST_DRAIN  = 2'd2;
    localparam logic [1:0] TRDB_ST_RSVD   = 2'd3;

    localparam logic [1:0] TRDB_CAUSE_NONE    = 2'd0;
    localparam logic [1:0] TRDB_CAUSE_SW      = 2'd1;
    localparam logic [1:0] TRDB_CAUSE_DEACT   = 2'd2;
    localparam logic [1:0] TRDB_CAUSE_TIMEOUT = 2'd3;

    // The reserved encoding is a named member so the FSM can recover from it.
    typedef enum logic [1:0] {
        ST_IDLE   = TRDB_ST_IDLE,
        ST_ACTIVE = TRDB_ST_ACTIVE,
        ST_DRAIN  = TRDB_ST_DRAIN,
        ST_RSVD   = TRDB_ST_RSVD
    } trdb_ctrl_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = TRDB_CAUSE_NONE,
        CAUSE_SW      = TRDB_CAUSE_SW,
        CAUSE_DEACT   = TRDB_CAUSE_DEACT,
        CAUSE_TIMEOUT = TRDB_CAUSE_TIMEOUT
    } trdb_stop_cause_e;

    function automatic logic trdb_is_busy(input trdb_ctrl_state_e s);
        return (s == ST_ACTIVE) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/trdb_drain_timer.sv
// Drain-phase cycle counter; expired_o flags the last permitted drain cycle
// (count == DRAIN_TIMEOUT-1). The counter holds at that value until cleared.
module trdb_drain_timer
    import trdb_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DRAIN_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_expired;

    assign w_expired = (r_cnt == LAST_CNT);
    assign expired_o = w_expired;

    // Drain cycle counter: cleared outside DRAIN, counts while enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (clear_i) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (enable_i && !w_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/trdb_trace_ctrl.sv
// Trace session controller: IDLE -> ACTIVE -> DRAIN with timeout and restart.
// Optional macro TRDB_TRIGGER_ON_EN lets trigger_trace_on_i start/restart tracing.
module trdb_trace_ctrl
    import trdb_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT = 1024,
    parameter int unsigned STOP_CNT_W    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sw_wr_i,
    input  logic                  sw_enable_i,
    input  logic                  trace_req_deactivate_i,
    input  logic                  trigger_trace_on_i,
    input  logic                  encoder_idle_i,
    output logic                  trace_enable_o,
    output logic                  busy_o,
    output logic [1:0]            state_o,
    output logic [1:0]            stop_cause_o,
    output logic [STOP_CNT_W-1:0] stop_cnt_o
);

    trdb_ctrl_state_e        r_state;
    trdb_ctrl_state_e        w_state_nxt;
    trdb_stop_cause_e        r_cause;
    trdb_stop_cause_e        w_cause_nxt;
    logic                    r_restart_pend;
    logic                    w_restart_pend_nxt;
    logic                    w_restart_eff;
    logic [STOP_CNT_W-1:0]   r_stop_cnt;
    logic [STOP_CNT_W-1:0]   w_stop_cnt_nxt;
    logic                    r_trace_en;
    logic                    r_busy;
    logic                    w_trig;
    logic                    w_in_drain;
    logic                    w_expired;

`ifdef TRDB_TRIGGER_ON_EN
    assign w_trig = trigger_trace_on_i;
`else
    logic w_unused_trig;
    assign w_unused_trig = trigger_trace_on_i;
    assign w_trig        = 1'b0;
`endif

    assign w_in_drain = (r_state == ST_DRAIN);

    trdb_drain_timer #(
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) u_drain_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (!w_in_drain),
        .enable_i (w_in_drain),
        .expired_o(w_expired)
    );

    // Restart request as seen this cycle: a sw write overrides a trigger,
    // so the last software word written is what decides the restart.
    assign w_restart_eff = sw_wr_i ? sw_enable_i : (r_restart_pend | w_trig);

    // Next-state, stop-cause, restart and session-count logic.
    always_comb begin
        w_state_nxt        = r_state;
        w_cause_nxt        = r_cause;
        w_restart_pend_nxt = 1'b0;
        w_stop_cnt_nxt     = r_stop_cnt;
        case (r_state)
            ST_IDLE: begin
                if ((sw_wr_i && sw_enable_i) || w_trig) begin
                    w_state_nxt = ST_ACTIVE;
                    w_cause_nxt = CAUSE_NONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (trace_req_deactivate_i) begin
                    w_state_nxt = ST_DRAIN;
                    w_cause_nxt = CAUSE_DEACT;
                end else if (sw_wr_i && !sw_enable_i) begin
                    w_state_nxt = ST_DRAIN;
                    w_cause_nxt = CAUSE_SW;
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_DRAIN: begin
                if (encoder_idle_i || w_expired) begin
                    w_stop_cnt_nxt = (r_stop_cnt == {STOP_CNT_W{1'b1}}) ?
                                     r_stop_cnt : (r_stop_cnt + STOP_CNT_W'(1));
                    if (w_restart_eff) begin
                        w_state_nxt = ST_ACTIVE;
                        w_cause_nxt = CAUSE_NONE;
                    end else if (!encoder_idle_i) begin
                        w_state_nxt = ST_IDLE;
                        w_cause_nxt = CAUSE_TIMEOUT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt        = ST_DRAIN;
                    w_restart_pend_nxt = w_restart_eff;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_cause        <= CAUSE_NONE;
            r_restart_pend <= 1'b0;
            r_stop_cnt     <= {STOP_CNT_W{1'b0}};
            r_trace_en     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cause        <= w_cause_nxt;
            r_restart_pend <= w_restart_pend_nxt;
            r_stop_cnt     <= w_stop_cnt_nxt;
            r_trace_en     <= (w_state_nxt == ST_ACTIVE);
            r_busy         <= trdb_is_busy(w_state_nxt);
        end
    end

    assign trace_enable_o = r_trace_en;
    assign busy_o         = r_busy;
    assign state_o        = r_state;
    assign stop_cause_o   = r_cause;
    assign stop_cnt_o     = r_stop_cnt;

endmodule
